// File: rtl/la_capture_dumper_if.sv
// -----------------------------------------------------------------------------
// la_capture_dumper_if
// Bus bundle between the logic-analyzer dumper, its capture buffer and its
// UART transmitter.
//   read_addr : capture buffer read address   (dumper -> buffer)
//   read_data : capture word, one clk latency (buffer -> dumper)
//   tx_data   : byte to transmit              (dumper -> UART)
//   tx_en     : one-cycle transmit strobe     (dumper -> UART)
//   tx_busy   : UART shifting a byte out      (UART   -> dumper)
// modport master : dumper side
// modport slave  : buffer/UART side
// -----------------------------------------------------------------------------
interface la_capture_dumper_if #(
    parameter int ADDR_BITS  = 9,
    parameter int DATA_WIDTH = 128
);
    logic [ADDR_BITS-1:0]  read_addr;
    logic [DATA_WIDTH-1:0] read_data;
    logic [7:0]            tx_data;
    logic                  tx_en;
    logic                  tx_busy;

    modport master (
        output read_addr,
        input  read_data,
        output tx_data,
        output tx_en,
        input  tx_busy
    );

    modport slave (
        input  read_addr,
        output read_data,
        input  tx_data,
        input  tx_en,
        output tx_busy
    );
endinterface

// File: rtl/la_capture_dumper.sv
// -----------------------------------------------------------------------------
// la_capture_dumper
// On a rising edge of the analyzer's done flag, reads every word of the
// capture buffer (2^ADDR_BITS words of DATA_WIDTH bits) and streams it out
// over a UART byte interface, most significant byte of each word first.
// Optional macro LA_DUMP_HEADER_EN: when defined, the ASCII header "RTLA"
// (0x52 0x54 0x4C 0x41) is sent before the data.
// Ports:
//   clk     : clock, all logic on posedge
//   rst_n   : asynchronous active-low reset
//   done    : analyzer capture-complete flag (level)
//   dumping : high from dump start until the last byte is accepted
//   bus     : la_capture_dumper_if.master (buffer read + UART transmit)
// -----------------------------------------------------------------------------
module la_capture_dumper #(
    parameter int ADDR_BITS  = 9,
    parameter int DATA_WIDTH = 128
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       done,
    output logic                       dumping,
    la_capture_dumper_if.master        bus
);
    localparam int NBYTES    = DATA_WIDTH / 8;
    localparam int BYTE_BITS = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
`ifdef LA_DUMP_HEADER_EN
        HEADER  = 3'd1,
`endif
        FETCH   = 3'd2,
        LATCH   = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5,
        HOLD    = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic                  done_q;
    logic [ADDR_BITS-1:0]  word_q, word_d;
    logic [BYTE_BITS-1:0]  byte_q, byte_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] next_shift_s;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  dumping_q, dumping_d;
    logic                  wait_first_q, wait_first_d;
    logic                  tx_en_s;
`ifdef LA_DUMP_HEADER_EN
    logic [1:0]            hdr_q, hdr_d;
    logic                  in_hdr_q, in_hdr_d;

    // Header ROM: "RTLA"
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h52;
            2'd1:    b = 8'h54;
            2'd2:    b = 8'h4C;
            default: b = 8'h41;
        endcase
        return b;
    endfunction
`endif

    assign next_shift_s = shift_q << 8;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            word_q       <= {ADDR_BITS{1'b0}};
            byte_q       <= {BYTE_BITS{1'b0}};
            shift_q      <= {DATA_WIDTH{1'b0}};
            tx_data_q    <= 8'h00;
            dumping_q    <= 1'b0;
            wait_first_q <= 1'b0;
`ifdef LA_DUMP_HEADER_EN
            hdr_q        <= 2'd0;
            in_hdr_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            done_q       <= done;
            word_q       <= word_d;
            byte_q       <= byte_d;
            shift_q      <= shift_d;
            tx_data_q    <= tx_data_d;
            dumping_q    <= dumping_d;
            wait_first_q <= wait_first_d;
`ifdef LA_DUMP_HEADER_EN
            hdr_q        <= hdr_d;
            in_hdr_q     <= in_hdr_d;
`endif
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        byte_d       = byte_q;
        shift_d      = shift_q;
        tx_data_d    = tx_data_q;
        wait_first_d = wait_first_q;
        tx_en_s      = 1'b0;
`ifdef LA_DUMP_HEADER_EN
        hdr_d        = hdr_q;
        in_hdr_d     = in_hdr_q;
`endif
        case (state_q)
            IDLE: begin
                if (done && !done_q) begin
                    word_d = {ADDR_BITS{1'b0}};
                    byte_d = {BYTE_BITS{1'b0}};
`ifdef LA_DUMP_HEADER_EN
                    hdr_d     = 2'd0;
                    in_hdr_d  = 1'b1;
                    tx_data_d = hdr_byte(2'd0);
                    state_d   = HEADER;
`else
                    state_d   = FETCH;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef LA_DUMP_HEADER_EN
            HEADER: begin
                if (!tx_busy_s()) begin
                    tx_en_s      = 1'b1;
                    wait_first_d = 1'b1;
                    state_d      = WAIT_TX;
                end else begin
                    state_d = HEADER;
                end
            end
`endif
            FETCH: begin
                // read_addr already equals word_q; data arrives next cycle
                state_d = LATCH;
            end
            LATCH: begin
                shift_d   = bus.read_data;
                tx_data_d = bus.read_data[DATA_WIDTH-1 -: 8];
                byte_d    = {BYTE_BITS{1'b0}};
                state_d   = SEND;
            end
            SEND: begin
                // strobe is gated by tx_busy in the same cycle so it can
                // never coincide with a busy UART
                if (!bus.tx_busy) begin
                    tx_en_s      = 1'b1;
                    wait_first_d = 1'b1;
                    state_d      = WAIT_TX;
                end else begin
                    state_d = SEND;
                end
            end
            WAIT_TX: begin
                // the UART raises busy only the cycle after tx_en, so the
                // first cycle here is skipped before looking at tx_busy
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (!bus.tx_busy) begin
`ifdef LA_DUMP_HEADER_EN
                    if (in_hdr_q) begin
                        if (hdr_q == 2'd3) begin
                            in_hdr_d = 1'b0;
                            state_d  = FETCH;
                        end else begin
                            hdr_d     = hdr_q + 2'd1;
                            tx_data_d = hdr_byte(hdr_q + 2'd1);
                            state_d   = HEADER;
                        end
                    end else
`endif
                    if (byte_q == BYTE_BITS'(NBYTES - 1)) begin
                        byte_d = {BYTE_BITS{1'b0}};
                        if (word_q == {ADDR_BITS{1'b1}}) begin
                            state_d = HOLD;
                        end else begin
                            word_d  = word_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
                            state_d = FETCH;
                        end
                    end else begin
                        byte_d    = byte_q + {{(BYTE_BITS-1){1'b0}}, 1'b1};
                        shift_d   = next_shift_s;
                        tx_data_d = next_shift_s[DATA_WIDTH-1 -: 8];
                        state_d   = SEND;
                    end
                end else begin
                    state_d = WAIT_TX;
                end
            end
            HOLD: begin
                if (!done) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        dumping_d = (state_d != IDLE) && (state_d != HOLD);
    end

`ifdef LA_DUMP_HEADER_EN
    // Readability wrapper so the HEADER branch mirrors SEND
    function automatic logic tx_busy_s();
        return bus.tx_busy;
    endfunction
`endif

    assign bus.read_addr = word_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_en     = tx_en_s;
    assign dumping       = dumping_q;

endmodule

// File: tb/tb_la_capture_dumper.sv
// -----------------------------------------------------------------------------
// tb_la_capture_dumper
// Randomised bench with a queue scoreboard. Each triggered dump pushes the
// whole expected byte stream (computed from the buffer contents rule); a
// monitor pops and compares on every tx_en. Small parameters keep runs short.
// -----------------------------------------------------------------------------
module tb_la_capture_dumper;
    localparam int AB  = 5;
    localparam int DW  = 64;
    localparam int NW  = 1 << AB;
    localparam int NB  = DW / 8;
`ifdef LA_DUMP_HEADER_EN
    localparam int HDR = 4;
`else
    localparam int HDR = 0;
`endif
    localparam int DUMP_BYTES = HDR + NW * NB;

    logic clk;
    logic rst_n;
    logic done;
    logic dumping;
    logic stall;

    la_capture_dumper_if #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) bus ();

    la_capture_dumper #(.ADDR_BITS(AB), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .done    (done),
        .dumping (dumping),
        .bus     (bus)
    );

    int         total = 0;
    int         bad   = 0;
    int         rx_cnt = 0;
    logic       prev_en = 1'b0;
    logic [7:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected stream: word i is i as 16 bits repeated; MSB byte first
    task automatic push_dump();
        logic [7:0] hdr[4];
        hdr[0] = 8'h52; hdr[1] = 8'h54; hdr[2] = 8'h4C; hdr[3] = 8'h41;
        for (int h = 0; h < HDR; h++) exp_q.push_back(hdr[h]);
        for (int w = 0; w < NW; w++)
            for (int b = 0; b < NB; b++)
                exp_q.push_back((b % 2 == 0) ? 8'((w >> 8) & 255) : 8'(w & 255));
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Capture buffer model: data valid one clk after the address
    initial begin
        logic [AB-1:0] a;
        bus.read_data = '0;
        forever begin
            @(negedge clk);
            a = bus.read_addr;
            @(posedge clk);
            #1;
            for (int k = 0; k < DW / 16; k++)
                bus.read_data[k*16 +: 16] = 16'(a);
        end
    end

    // UART model: random busy time after every accepted byte, plus stall
    initial begin
        int   busy_cnt;
        logic en_n;
        busy_cnt    = 0;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            en_n = bus.tx_en;
            @(posedge clk);
            #1;
            if (en_n) busy_cnt = $urandom_range(1, 12);
            else if (busy_cnt > 0) busy_cnt--;
            bus.tx_busy = (busy_cnt > 0) || stall;
        end
    end

    // Monitor: protocol checks and scoreboard pop on every strobe
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus.tx_en) begin
                check("en_while_busy", {31'd0, bus.tx_busy}, 32'd0);
                check("en_back_to_back", {31'd0, prev_en}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h expected none", bus.tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {24'd0, bus.tx_data}, {24'd0, e});
                end
                rx_cnt++;
            end
            prev_en = bus.tx_en;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && dumping == 1'b0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 20000) begin
            bad++;
            $display("FAIL %s_timeout: got %0d bytes left expected 0", nm, exp_q.size());
        end
        cycles(1);
    endtask

    initial begin
        int start;
        int n;
        rst_n = 1'b0;
        done  = 1'b0;
        stall = 1'b0;
        cycles(3);
        check("rst_dumping", {31'd0, dumping}, 32'd0);
        check("rst_tx_en", {31'd0, bus.tx_en}, 32'd0);
        check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        check("rst_read_addr", 32'(bus.read_addr), 32'd0);
        rst_n = 1'b1;
        cycles(2);

        // Dump A: short done pulse, with a long mid-word stall
        start = rx_cnt;
        push_dump();
        done = 1'b1;
        cycles($urandom_range(1, 5));
        check("dumping_high", {31'd0, dumping}, 32'd1);
        done = 1'b0;
        n = 0;
        while (rx_cnt - start < HDR + 3 * NB + 3 && n < 5000) begin cycles(1); n++; end
        check("stall_reached", {31'd0, n >= 5000}, 32'd0);
        stall = 1'b1;
        n = rx_cnt;
        cycles(1000);
        check("stall_no_bytes", 32'(rx_cnt), 32'(n));
        stall = 1'b0;
        wait_idle("dump_a");
        check("dump_a_count", 32'(rx_cnt - start), 32'(DUMP_BYTES));
        check("dump_a_dumping_low", {31'd0, dumping}, 32'd0);

        // Dump B: done held high through completion, no retrigger
        start = rx_cnt;
        push_dump();
        done = 1'b1;
        wait_idle("dump_b");
        cycles(60);
        check("dump_b_count", 32'(rx_cnt - start), 32'(DUMP_BYTES));
        check("hold_dumping_low", {31'd0, dumping}, 32'd0);

        // Dump C: fresh rising edge gives an identical dump
        done = 1'b0;
        cycles($urandom_range(2, 6));
        start = rx_cnt;
        push_dump();
        done = 1'b1;
        cycles(2);
        done = 1'b0;
        wait_idle("dump_c");
        check("dump_c_count", 32'(rx_cnt - start), 32'(DUMP_BYTES));

        // Reset mid-dump at word 10
        push_dump();
        done = 1'b1;
        cycles(2);
        done = 1'b0;
        n = 0;
        while (bus.read_addr != AB'(10) && n < 5000) begin cycles(1); n++; end
        check("word10_reached", {31'd0, n >= 5000}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dumping", {31'd0, dumping}, 32'd0);
        check("mid_rst_tx_en", {31'd0, bus.tx_en}, 32'd0);
        check("mid_rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
        check("mid_rst_read_addr", 32'(bus.read_addr), 32'd0);
        exp_q.delete();
        cycles(3);
        rst_n = 1'b1;
        n = rx_cnt;
        cycles(100);
        check("post_rst_quiet", 32'(rx_cnt), 32'(n));
        check("post_rst_dumping", {31'd0, dumping}, 32'd0);

        // Dump D after reset starts again at word 0
        start = rx_cnt;
        push_dump();
        done = 1'b1;
        cycles($urandom_range(1, 4));
        done = 1'b0;
        wait_idle("dump_d");
        check("dump_d_count", 32'(rx_cnt - start), 32'(DUMP_BYTES));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
